// File: rtl/alu_operand_sequencer_if.sv
// Signal bundle between the operand sequencer, the switch/button
// inputs and the lab ALU it drives.
interface alu_operand_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0]   sw;
    logic           btn_n;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [3:0]     operator;
    logic [2*N-1:0] alu_result;
    logic [3:0]     alu_flags;
    logic [2*N-1:0] result_q;
    logic [3:0]     flags_q;
    logic           done;
    logic [1:0]     phase;

    modport master (
        input  sw, btn_n, alu_result, alu_flags,
        output a, b, operator, result_q, flags_q,
        output done, phase
    );

    modport slave (
        output sw, btn_n, alu_result, alu_flags,
        input  a, b, operator, result_q, flags_q,
        input  done, phase
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Debounced single-button entry of A, B and op code for the lab ALU,
// then a one-cycle execute step that latches the ALU result and flags.
module alu_operand_sequencer #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    alu_operand_sequencer_if.master bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    logic          sync1, sync2, deb;
    logic [CW-1:0] cnt;
    logic          flip, press;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]     op_q, op_d;
    logic [2*N-1:0] res_q, res_d;
    logic [3:0]     flg_q, flg_d;
    logic           done_q, done_d;

    assign flip  = (sync2 != deb) && (cnt == CNT_LAST);
    // deb still high means this flip is released -> pressed
    assign press = flip && deb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            deb   <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= bus.btn_n;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (flip) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_A: begin
                if (press) begin
                    a_d     = bus.sw;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    b_d     = bus.sw;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (press) begin
                    op_d    = bus.sw[3:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // a press landing here is intentionally dropped
                res_d   = bus.alu_result;
                flg_d   = bus.alu_flags;
                done_d  = 1'b1;
                state_d = S_A;
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            done_q  <= done_d;
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.operator = op_q;
    assign bus.result_q = res_q;
    assign bus.flags_q  = flg_q;
    assign bus.done     = done_q;
    assign bus.phase    = state_q;
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream stage of the lab ALU; drives the ALU operands `a`, `b` and the `Operator` code.
- A shared switch bank and one pushbutton enter A, then B, then the operation code, in that order.
- After the operation code is entered, the ALU's combinational result and flags are captured into registers, with a one-cycle done pulse.
- The registered values hold steady for the 7-segment decoder until the next entry cycle.

Parameters:
- N, 4, operand width; must match ALU parameter n; N >= 4 required.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized-button cycles needed to accept a level change (10 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  N  raw slide-switch data; quasi-static, sampled only on accepted press.
- btn_n  input  1  raw pushbutton, active-low, asynchronous, bouncing.
- a  output  N  registered operand A to ALU.
- b  output  N  registered operand B to ALU.
- operator  output  4  registered ALU operation code.
- alu_result  input  2N  ALU Result.
- alu_flags  input  4  ALU flags, packed {N,Z,C,V}.
- result_q  output  2N  captured result.
- flags_q  output  4  captured flags {N,Z,C,V}.
- done  output  1  one-cycle pulse when result_q/flags_q update.
- phase  output  2  current FSM state encoding, for LEDs.

Behaviour:
Reset:
- a, b, operator, result_q, flags_q = 0; done = 0; phase = S_A (2'd0).
- Synchronizer flops preset to 1 (released); debounce counter = 0; debounced level = released.
- Reset mid-operation abandons any partial entry; no capture occurs.

Button path:
- 2-flop synchronizer on btn_n.
- Counter increments while the synchronized level differs from the debounced level; it clears when they match.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- A released->pressed flip generates `press`, a single one-cycle internal pulse.
- Release is debounced identically; holding the button yields exactly one press.
- Any bounce shorter than DEBOUNCE_CYCLES is ignored.
- Latency from a clean btn_n falling edge to `press`: 2 + DEBOUNCE_CYCLES cycles (±1).

FSM (phase encoding S_A=0, S_B=1, S_OP=2, S_EXEC=3):
- S_A: on press, a <= sw; go S_B.
- S_B: on press, b <= sw; go S_OP.
- S_OP: on press, operator <= sw[3:0]; go S_EXEC.
- S_EXEC: lasts exactly one cycle, which gives the ALU a full cycle with registered inputs. At the end of the cycle: result_q <= alu_result, flags_q <= alu_flags, done <= 1 for the next cycle only; go S_A.
- A press coinciding with S_EXEC is dropped and not queued. This is not reachable in practice because of the release debounce, but it is required.
- a, b and operator keep their old values until individually overwritten. During re-entry the ALU shows intermediate combinations; result_q is unaffected until the next S_EXEC.
- sw is sampled only in the cycle `press` is high; sw changes at other times have no effect.
- No arithmetic is performed here; widths pass through unchanged. Bits sw[N-1:4] are ignored when loading operator.

Test Plan (N=4, DEBOUNCE_CYCLES=4, real ALU instance connected):
1. Reset, then sw=0011 press, sw=0101 press, sw=0000 press -> a=3, b=5, operator=0; one cycle after S_EXEC: result_q=8'h08, flags_q=4'b1001, done high exactly 1 cycle, phase=0.
2. btn_n low pulses of 1, 2 and 3 cycles separated by 2-cycle high gaps, then held high -> no press, phase stays 0, a unchanged.
3. btn_n held low 100 cycles with sw=1010 -> exactly one capture: a=4'hA, phase=1; sw toggled while held -> a stays 4'hA.
4. Full entry a=7, b=3, op=0010 (MUL) -> result_q=8'h15, done pulse; then new entry a=2 only -> result_q still 8'h15, a=2, b=3 retained.
5. Assert rst_n low asynchronously mid-cycle while phase=2 with a=5, b=6 -> immediately a=b=operator=0, result_q=0, phase=0. After release, a clean press loads a from sw.
6. Entry a=6, b=0, op=0011 (DIV) -> result_q and flags_q equal whatever the ALU drives that cycle, captured in S_EXEC; done=1 once; no X on result_q in zero-delay simulation (bench flags X).
